// File: rtl/user_io_ports.sv
// Wishbone GPIO block owning the button and LED pads: debounced buttons with
// sticky edge flags and an interrupt, register-driven or auto-mirrored LEDs.

module btn_lane #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic wb_clk_i,
   input  logic wb_rstn_i,
   input  logic pin,
   output logic stable,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;
   logic          accept;

   // rise/fall pulse on the same edge that updates stable
   assign accept = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign rise   = accept & s2;
   assign fall   = accept & ~s2;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         s1 <= pin;
         s2 <= s1;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module user_io_ports #(
   parameter logic [31:0] BASE_ADR        = 32'h3000_0000,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [37:0] io_in,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb,
   output logic [2:0]  irq
);
   localparam int NUM_LANES = 3;

   localparam logic [2:0] R_LED   = 3'd0;
   localparam logic [2:0] R_BTN   = 3'd1;
   localparam logic [2:0] R_FLAGS = 3'd2;
   localparam logic [2:0] R_IRQEN = 3'd3;
   localparam logic [2:0] R_CTRL  = 3'd4;

   logic [NUM_LANES-1:0] stable, rise, fall;
   logic [NUM_LANES-1:0] rise_f, fall_f;
   logic [NUM_LANES-1:0] w1c_rise, w1c_fall;
   logic [7:0]           led;
   logic [6:0]           irqen;
   logic                 auto_mode, led_oe;
   logic                 hit, acc, wr_en;
   logic [2:0]           reg_sel;
   logic [31:0]          rdata;
   logic [6:0]           flags;
   logic [7:0]           led_pads;

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .wb_clk_i (wb_clk_i),
            .wb_rstn_i(wb_rstn_i),
            .pin      (io_in[7+i]),
            .stable   (stable[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
         );
      end
   endgenerate

   // acc gates on ~ack so a held strobe is accepted only every other cycle
   assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign acc     = hit & ~wbs_ack_o;
   assign wr_en   = acc & wbs_we_i & wbs_sel_i[0];
   assign reg_sel = wbs_adr_i[4:2];

   assign flags = {fall_f, 1'b0, rise_f};

   always_comb begin
      rdata = 32'h0;
      case (reg_sel)
         R_LED:   rdata[7:0] = led;
         R_BTN:   rdata[2:0] = stable;
         R_FLAGS: rdata[6:0] = flags;
         R_IRQEN: rdata[6:0] = irqen;
         R_CTRL:  rdata[1:0] = {led_oe, auto_mode};
         default: rdata = 32'h0;
      endcase
   end

   always_comb begin
      w1c_rise = '0;
      w1c_fall = '0;
      if (wr_en && reg_sel == R_FLAGS) begin
         w1c_rise = wbs_dat_i[2:0];
         w1c_fall = wbs_dat_i[6:4];
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= 32'h0;
      end else begin
         wbs_ack_o <= acc;
         wbs_dat_o <= (acc && !wbs_we_i) ? rdata : 32'h0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         led       <= 8'h0;
         irqen     <= 7'h0;
         auto_mode <= 1'b0;
         led_oe    <= 1'b0;
      end else if (wr_en) begin
         case (reg_sel)
            R_LED:   led <= wbs_dat_i[7:0];
            R_IRQEN: irqen <= wbs_dat_i[6:0];
            R_CTRL:  {led_oe, auto_mode} <= wbs_dat_i[1:0];
            default: ;
         endcase
      end
   end

   // a new edge outranks a simultaneous clear of the same bit
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         rise_f <= '0;
         fall_f <= '0;
      end else begin
         rise_f <= (rise_f & ~w1c_rise) | rise;
         fall_f <= (fall_f & ~w1c_fall) | fall;
      end
   end

   assign irq      = {2'b00, |(flags & irqen)};
   assign led_pads = auto_mode ? {stable[1:0], stable, stable} : led;
   assign io_out   = {20'h0, led_pads, 10'h0};
   assign io_oeb   = {20'hF_FFFF, ~{8{led_oe}}, 10'h3FF};

   logic unused_ok;
   assign unused_ok = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[7:5], wbs_adr_i[1:0],
                        wbs_dat_i[31:8], io_in[37:10], io_in[6:0]};
endmodule
